// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles every signal between the arbiter, the core's fetch and load/store
// ports and the byte-wide data memory.
//   Fetch port : if_req, if_addr in; if_rdata, if_ack, if_err out
//   Data port  : d_req, d_we, d_addr, d_wdata in; d_rdata, d_ack, d_err out
//   Memory     : mem_addr, mem_wdata, mem_read, mem_write out; mem_rdata in
//   Status     : busy out
// The slave modport is the arbiter's view. The master modport is the view of
// the core and memory that surround it.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        if_err;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_err;

  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_read;
  logic        mem_write;

  logic        busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ack, if_err, d_rdata, d_ack, d_err,
           mem_addr, mem_wdata, mem_read, mem_write, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ack, if_err, d_rdata, d_ack, d_err,
           mem_addr, mem_wdata, mem_read, mem_write, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one byte-wide data memory between the instruction-fetch port and
// the load/store port. Each granted word request becomes four big-endian
// byte beats. Read beats are assembled into a 32-bit word. Completion is
// signalled with a one-cycle ack, and with err when the request was rejected.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous active-high reset
//   bus   : mem_port_arbiter_if.slave carrying fetch, data, memory and busy
// Parameter:
//   MEM_BYTES : memory size in bytes; legal word addresses are 0..MEM_BYTES-4
module mem_port_arbiter #(
  parameter int MEM_BYTES = 160
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] MaxAddr = 32'(MEM_BYTES - 4);

  state_t      r_state;
  state_t      w_nextState;
  logic [1:0]  r_beat;
  logic        r_lastGrant;
  logic        r_grant;
  logic        r_we;
  logic        r_err;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_word;
  logic [31:0] r_ifRdata;
  logic [31:0] r_dRdata;

  logic        w_anyReq;
  logic        w_pickData;
  logic [31:0] w_reqAddr;
  logic        w_reject;

  logic        w_memRead;
  logic        w_memWrite;
  logic [31:0] w_memAddr;
  logic [7:0]  w_memWdata;
  logic        w_ifAck;
  logic        w_dAck;
  logic        w_ifErr;
  logic        w_dErr;
  logic        w_busy;

  // On a tie the data port wins unless it was the last port granted, so
  // continuous contention strictly alternates between the two ports.
  always_comb begin
    w_anyReq   = bus.if_req | bus.d_req;
    w_pickData = bus.d_req & (~bus.if_req | ~r_lastGrant);
    w_reqAddr  = w_pickData ? bus.d_addr : bus.if_addr;
    w_reject   = (w_reqAddr[1:0] != 2'b00) || (w_reqAddr > MaxAddr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Strobes are gated with reset so that a beat aborted by reset does not
  // commit its byte at the same edge that returns the FSM to IDLE.
  always_comb begin
    w_nextState = r_state;
    w_memRead   = 1'b0;
    w_memWrite  = 1'b0;
    w_memAddr   = 32'd0;
    w_memWdata  = 8'd0;
    w_ifAck     = 1'b0;
    w_dAck      = 1'b0;
    w_ifErr     = 1'b0;
    w_dErr      = 1'b0;
    w_busy      = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (w_anyReq) begin
          w_nextState = w_reject ? RESP : XFER;
        end
      end
      XFER: begin
        w_memRead  = ~r_we & ~reset;
        w_memWrite = r_we & ~reset;
        w_memAddr  = r_addr + {30'd0, r_beat};
        if (r_we) begin
          case (r_beat)
            2'd0:    w_memWdata = r_wdata[31:24];
            2'd1:    w_memWdata = r_wdata[23:16];
            2'd2:    w_memWdata = r_wdata[15:8];
            default: w_memWdata = r_wdata[7:0];
          endcase
        end
        if (r_beat == 2'd3) begin
          w_nextState = RESP;
        end
      end
      RESP: begin
        w_ifAck     = ~r_grant;
        w_dAck      = r_grant;
        w_ifErr     = ~r_grant & r_err;
        w_dErr      = r_grant & r_err;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // The grant latches everything the transfer needs. Read beats shift in
  // from the right, so beat 0 ends up in bits 31:24. The completed word is
  // committed to the port's read register at the end of RESP. Stores and
  // rejected requests leave both read registers untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_beat      <= 2'd0;
      r_lastGrant <= 1'b0;
      r_grant     <= 1'b0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_word      <= 32'd0;
      r_ifRdata   <= 32'd0;
      r_dRdata    <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_grant     <= w_pickData;
            r_lastGrant <= w_pickData;
            r_addr      <= w_reqAddr;
            r_we        <= w_pickData & bus.d_we;
            r_wdata     <= bus.d_wdata;
            r_err       <= w_reject;
            r_beat      <= 2'd0;
            r_word      <= 32'd0;
          end
        end
        XFER: begin
          r_beat <= r_beat + 2'd1;
          if (!r_we) begin
            r_word <= {r_word[23:0], bus.mem_rdata};
          end
        end
        RESP: begin
          if (!r_err && !r_we) begin
            if (r_grant) begin
              r_dRdata <= r_word;
            end else begin
              r_ifRdata <= r_word;
            end
          end
        end
        default: begin
          r_beat <= 2'd0;
        end
      endcase
    end
  end

  // Read data is forwarded in the ack cycle itself. The register then holds
  // the word until the next successful read on that port.
  assign bus.if_rdata  = (r_state == RESP && !r_grant && !r_err) ? r_word : r_ifRdata;
  assign bus.d_rdata   = (r_state == RESP && r_grant && !r_we && !r_err) ? r_word : r_dRdata;
  assign bus.if_ack    = w_ifAck;
  assign bus.if_err    = w_ifErr;
  assign bus.d_ack     = w_dAck;
  assign bus.d_err     = w_dErr;
  assign bus.mem_addr  = w_memAddr;
  assign bus.mem_wdata = w_memWdata;
  assign bus.mem_read  = w_memRead;
  assign bus.mem_write = w_memWrite;
  assign bus.busy      = w_busy;

endmodule
